edge_window_ctrl: RTL and testbench

EDGE_WINDOW_CTRL -- requirements
Module: edge_window_ctrl

---
 rtl/edge_window_ctrl_pkg.sv | 21 ++
 rtl/edge_window_ctrl_if.sv | 29 ++
 rtl/edge_addr_gen.sv | 18 +
 rtl/edge_window_ctrl.sv | 136 +++++++++++++
 tb/tb_edge_window_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_window_ctrl_pkg.sv
// Shared window geometry, controller states and result beat for the 5x5 edge-window controller.
package edge_window_ctrl_pkg;

  localparam int KSIZE = 5;
  localparam int PIX_W = 8;
  localparam int WIN_W = KSIZE * KSIZE * PIX_W;

  typedef enum logic [2:0] {IDLE, FILL, SHIFT, EMIT, FIN} state_t;

  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic [7:0]       x;
    logic [7:0]       y;
  } out_beat_t;

  // Byte slot of window pixel (r, c) within win_out.
  function automatic int win_idx(input int r, input int c);
    return KSIZE * r + c;
  endfunction

endpackage

// File: rtl/edge_window_ctrl_if.sv
// Control, pixel-memory read, kernel and result-stream signals of the edge-window controller.
interface edge_window_ctrl_if #(parameter int AW = 12);
  import edge_window_ctrl_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [7:0]       rd_data;
  logic [WIN_W-1:0] win_out;
  logic [PIX_W-1:0] kern_in;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic [7:0]       out_x;
  logic [7:0]       out_y;

  modport master (
    input  start, rd_data, kern_in, out_ready,
    output busy, done, rd_en, rd_addr, win_out, out_valid, out_pixel, out_x, out_y
  );

  modport slave (
    output start, rd_data, kern_in, out_ready,
    input  busy, done, rd_en, rd_addr, win_out, out_valid, out_pixel, out_x, out_y
  );

endinterface

// File: rtl/edge_addr_gen.sv
// Pixel-memory address for window origin plus (row, col) offset: (y+row)*IMG_W + x+col.
module edge_addr_gen #(
  parameter int IMG_W = 64,
  parameter int AW    = 12
) (
  input  logic [7:0]    org_x,
  input  logic [7:0]    org_y,
  input  logic [2:0]    col_off,
  input  logic [2:0]    row_off,
  output logic [AW-1:0] addr
);
  logic [AW-1:0] row, col;

  assign row  = AW'(org_y) + AW'(row_off);
  assign col  = AW'(org_x) + AW'(col_off);
  assign addr = row * AW'(IMG_W) + col;

endmodule

// File: rtl/edge_window_ctrl.sv
// Raster-scans 5x5 windows over an image: fills/shifts the window from pixel memory,
// presents it to an external kernel and streams one registered result per origin.
module edge_window_ctrl
  import edge_window_ctrl_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW    = 12
) (
  input logic                clk,
  input logic                rst,
  edge_window_ctrl_if.master bus
);
  localparam int NFILL = KSIZE * KSIZE;

  state_t           state, state_nx;
  logic [7:0]       x, y;
  logic [4:0]       rd_cnt;
  logic [2:0]       row_off, col_off, cap_r, cap_c;
  logic             cap_vld, rd_en, hs, x_end, y_end, last_cap;
  logic [WIN_W-1:0] win;
  out_beat_t        beat;
  logic             out_valid;
  logic [AW-1:0]    addr;

  assign hs       = out_valid & bus.out_ready;
  assign x_end    = (x == 8'(IMG_W - KSIZE));
  assign y_end    = (y == 8'(IMG_H - KSIZE));
  // The state may only move on once the final read of the burst has landed in the window.
  assign last_cap = cap_vld && (rd_cnt == ((state == FILL) ? 5'(NFILL) : 5'(KSIZE)));

  edge_addr_gen #(.IMG_W(IMG_W), .AW(AW)) u_addr (
    .org_x   (x),
    .org_y   (y),
    .col_off (col_off),
    .row_off (row_off),
    .addr    (addr)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nx = FILL;
      FILL:  begin
        rd_en = (rd_cnt < 5'(NFILL));
        if (last_cap) state_nx = EMIT;
      end
      SHIFT: begin
        rd_en = (rd_cnt < 5'(KSIZE));
        if (last_cap) state_nx = EMIT;
      end
      EMIT:  if (hs) state_nx = !x_end ? SHIFT : (!y_end ? FILL : FIN);
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      rd_cnt    <= '0;
      row_off   <= '0;
      col_off   <= '0;
      cap_r     <= '0;
      cap_c     <= '0;
      cap_vld   <= 1'b0;
      win       <= '0;
      beat      <= '0;
      out_valid <= 1'b0;
    end else begin
      cap_vld <= rd_en;
      if (rd_en) begin
        cap_r  <= row_off;
        cap_c  <= col_off;
        rd_cnt <= rd_cnt + 5'd1;
        if (row_off == 3'(KSIZE - 1)) begin
          row_off <= '0;
          col_off <= col_off + 3'd1;
        end else begin
          row_off <= row_off + 3'd1;
        end
      end
      if (cap_vld) win[PIX_W*win_idx(int'(cap_r), int'(cap_c)) +: PIX_W] <= bus.rd_data;

      case (state)
        IDLE: if (bus.start) begin
          x       <= '0;
          y       <= '0;
          rd_cnt  <= '0;
          row_off <= '0;
          col_off <= '0;
        end
        EMIT: begin
          // First EMIT cycle: window is complete, so the kernel result is now meaningful.
          if (!out_valid) begin
            beat      <= '{pixel: bus.kern_in, x: x, y: y};
            out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            rd_cnt    <= '0;
            row_off   <= '0;
            if (!x_end) begin
              x       <= x + 8'd1;
              col_off <= 3'(KSIZE - 1);
              for (int r = 0; r < KSIZE; r++)
                for (int c = 0; c < KSIZE - 1; c++)
                  win[PIX_W*win_idx(r, c) +: PIX_W] <= win[PIX_W*win_idx(r, c + 1) +: PIX_W];
            end else begin
              x       <= '0;
              y       <= y + 8'd1;
              col_off <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FIN);
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_en ? addr : '0;
  assign bus.win_out   = win;
  assign bus.out_valid = out_valid;
  assign bus.out_pixel = beat.pixel;
  assign bus.out_x     = beat.x;
  assign bus.out_y     = beat.y;

endmodule

// File: tb/tb_edge_window_ctrl.sv
// Scoreboard bench: expected read addresses and results are queued at start, popped as the DUTs emit.
module tb_edge_window_ctrl;
  import edge_window_ctrl_pkg::*;

  localparam int AW = 12;

  typedef struct {
    logic [7:0] pix;
    logic [7:0] x;
    logic [7:0] y;
    bit         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] a5[$], a8[$];
  exp_t          o5[$], o8[$];
  bit            pv[2], plast[2];
  logic [23:0]   pbeat[2];

  edge_window_ctrl_if #(.AW(AW)) b5 ();
  edge_window_ctrl_if #(.AW(AW)) b8 ();

  edge_window_ctrl #(.IMG_W(5), .IMG_H(5), .AW(AW)) dut5 (.clk(clk), .rst(rst), .bus(b5.master));
  edge_window_ctrl #(.IMG_W(8), .IMG_H(6), .AW(AW)) dut8 (.clk(clk), .rst(rst), .bus(b8.master));

  // Memories: 5x5 holds pixel = address (= 5r+c); 8x6 holds pixel = column*10.
  always @(posedge clk) begin
    if (b5.rd_en) b5.rd_data <= b5.rd_addr[7:0];
    if (b8.rd_en) b8.rd_data <= 8'(int'(b8.rd_addr[2:0]) * 10);
  end

  assign b5.kern_in = b5.win_out[8*12 +: 8] + b5.win_out[8*24 +: 8];
  assign b8.kern_in = b8.win_out[39:32] - b8.win_out[7:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input bit big, input int a);
    if (big) a8.push_back(AW'(a));
    else     a5.push_back(AW'(a));
  endtask

  task automatic push_img(input bit big);
    int   w, h;
    exp_t e;
    w = big ? 8 : 5;
    h = big ? 6 : 5;
    for (int y = 0; y <= h - 5; y++)
      for (int x = 0; x <= w - 5; x++) begin
        if (x == 0) begin
          for (int c = 0; c < 5; c++)
            for (int r = 0; r < 5; r++) push_a(big, (y + r) * w + c);
        end else begin
          for (int r = 0; r < 5; r++) push_a(big, (y + r) * w + x + 4);
        end
        e.x    = 8'(x);
        e.y    = 8'(y);
        e.last = (x == w - 5) && (y == h - 5);
        e.pix  = big ? 8'd40 : 8'd36;
        if (big) o8.push_back(e);
        else     o5.push_back(e);
      end
  endtask

  task automatic mon(input bit big, input logic rd_en, input logic [AW-1:0] addr,
                     input logic ov, input logic ordy, input logic [7:0] pix,
                     input logic [7:0] ox, input logic [7:0] oy, input logic done,
                     input logic [WIN_W-1:0] win);
    int            i;
    bit            hs, empty;
    logic [AW-1:0] ea;
    exp_t          e;
    i = big ? 1 : 0;
    if (rd_en) begin
      empty = big ? (a8.size() == 0) : (a5.size() == 0);
      if (empty) chk("rd_extra", 32'(rd_en), 32'd0);
      else begin
        if (big) ea = a8.pop_front();
        else     ea = a5.pop_front();
        chk("rd_addr", 32'(addr), 32'(ea));
      end
    end
    chk("done", 32'(done), 32'(plast[i]));
    if (pv[i]) chk("hold", 32'({ov, pix, ox, oy}), 32'({1'b1, pbeat[i]}));
    if (ov) chk("no_rd_in_emit", 32'(rd_en), 32'd0);
    hs       = ov && ordy;
    plast[i] = 1'b0;
    if (hs) begin
      empty = big ? (o8.size() == 0) : (o5.size() == 0);
      if (empty) chk("out_extra", 32'(ov), 32'd0);
      else begin
        if (big) e = o8.pop_front();
        else     e = o5.pop_front();
        chk("out_pix_x_y", 32'({pix, ox, oy}), 32'({e.pix, e.x, e.y}));
        plast[i] = e.last;
        if (!big)
          for (int k = 0; k < 25; k++) chk("win_byte", 32'(win[8*k +: 8]), 32'(k));
      end
    end
    pv[i]    = ov && !hs;
    pbeat[i] = {pix, ox, oy};
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv    = '{default: 1'b0};
      plast = '{default: 1'b0};
    end else begin
      mon(1'b0, b5.rd_en, b5.rd_addr, b5.out_valid, b5.out_ready, b5.out_pixel,
          b5.out_x, b5.out_y, b5.done, b5.win_out);
      mon(1'b1, b8.rd_en, b8.rd_addr, b8.out_valid, b8.out_ready, b8.out_pixel,
          b8.out_x, b8.out_y, b8.done, b8.win_out);
    end
  end

  // All driving tasks assume the caller sits #1 after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit big);
    if (big) b8.start = 1'b1; else b5.start = 1'b1;
    tick();
    b8.start = 1'b0;
    b5.start = 1'b0;
  endtask

  task automatic wait_done(input bit big, input int budget);
    int t;
    t = 0;
    while (!(big ? b8.done : b5.done) && t < budget) begin
      tick();
      t++;
    end
    chk("done_reached", 32'(big ? b8.done : b5.done), 32'd1);
  endtask

  // Accepts n results from the 8x6 DUT, stalling `stall` cycles at origin (1,0).
  task automatic consume8(input int n, input int stall);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!b8.out_valid && t < 200) begin
        tick();
        t++;
      end
      chk("valid_reached", 32'(b8.out_valid), 32'd1);
      if (b8.out_x == 8'd1 && b8.out_y == 8'd0) repeat (stall) tick();
      b8.out_ready = 1'b1;
      tick();
      b8.out_ready = 1'b0;
    end
  endtask

  initial begin
    int t;
    b5.start     = 1'b0;
    b8.start     = 1'b0;
    b5.out_ready = 1'b1;
    b8.out_ready = 1'b1;

    tick();
    chk("rst_state", 32'({b8.busy, b8.rd_en, b8.out_valid, b8.done, b8.out_pixel, b8.out_x}),
        32'd0);
    chk("rst_addr_win", 32'({b8.rd_addr, b8.out_y, |b8.win_out}), 32'd0);
    tick();
    rst = 1'b0;

    // Reset idle: nothing moves without start.
    repeat (8) begin
      tick();
      chk("idle5", 32'({b5.busy, b5.rd_en, b5.out_valid, b5.done}), 32'd0);
    end

    // Minimum image.
    push_img(1'b0);
    pulse_start(1'b0);
    wait_done(1'b0, 200);
    tick();
    chk("q5_drained", 32'(a5.size() + o5.size()), 32'd0);
    chk("idle5_after", 32'(b5.busy), 32'd0);

    // Vertical step, full speed; start during FIN must be ignored.
    push_img(1'b1);
    pulse_start(1'b1);
    wait_done(1'b1, 2000);
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    chk("fin_start_ignored", 32'(b8.busy), 32'd0);
    chk("q8_drained", 32'(a8.size() + o8.size()), 32'd0);

    // Back-pressure at origin (1,0).
    b8.out_ready = 1'b0;
    push_img(1'b1);
    pulse_start(1'b1);
    consume8(8, 7);
    wait_done(1'b1, 50);
    tick();
    chk("q8_drained_bp", 32'(a8.size() + o8.size()), 32'd0);
    b8.out_ready = 1'b1;

    // Mid-image reset during SHIFT at origin (2,1).
    push_img(1'b1);
    pulse_start(1'b1);
    t = 0;
    while (!(b8.out_valid && b8.out_x == 8'd1 && b8.out_y == 8'd1) && t < 500) begin
      tick();
      t++;
    end
    chk("reached_1_1", 32'({b8.out_x, b8.out_y}), 32'h0101);
    tick();
    tick();
    chk("in_shift", 32'({b8.busy, b8.rd_en, b8.out_valid}), 32'b110);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 32'({b8.busy, b8.rd_en, b8.out_valid, b8.done, b8.out_pixel, b8.out_x}),
        32'd0);
    chk("rst_async_addr", 32'({b8.rd_addr, b8.out_y, |b8.win_out}), 32'd0);
    a8.delete();
    o8.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("idle_after_abort", 32'({b8.busy, b8.rd_en, b8.out_valid}), 32'd0);
    end
    push_img(1'b1);
    pulse_start(1'b1);
    repeat (3) tick();
    pulse_start(1'b1);
    wait_done(1'b1, 2000);
    tick();
    chk("q8_drained_rerun", 32'(a8.size() + o8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
